// File: rtl/lsu_mem_stage.sv
`default_nettype none
// lsu_mem_stage: load/store unit driving a word-wide dmem; sub-word stores use read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN: report misaligned requests instead of force-aligning them.
module lsu_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        resp_misaligned,
  output logic [31:0] dmem_read,
  output logic [31:0] dmem_write,
  output logic        dmem_rd_en,
  output logic        dmem_wr_en,
  output logic [31:0] dmem_in_data,
  input  logic [31:0] dmem_out_data
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LD_RD  = 3'd1;
  localparam logic [2:0] LD_CAP = 3'd2;
  localparam logic [2:0] ST_RD  = 3'd3;
  localparam logic [2:0] ST_CAP = 3'd4;
  localparam logic [2:0] ST_WR  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [15:0] wdata_q;
  logic [4:0]  rd_q;
  logic        store_q;
  logic [31:0] merge_q, merge_d;
  logic        resp_valid_q;
  logic [4:0]  resp_rd_q;
  logic [31:0] resp_data_q;

  logic        accept, is_word, is_half, misaligned, trap;
  logic [31:0] addr_eff, shifted, load_data;

  assign req_ready  = (state_q == IDLE) && !rst;
  assign accept     = req_valid && req_ready;
  // funct3[1] set selects the word path for both loads and stores (covers the reserved codes)
  assign is_word    = req_funct3[1];
  assign is_half    = (req_funct3[1:0] == 2'b01);
  assign misaligned = (is_word && (req_addr[1:0] != 2'b00)) || (is_half && req_addr[0]);

`ifdef LSU_MISALIGN_TRAP_EN
  logic trap_q;
  logic resp_mis_q;
  assign trap            = misaligned;
  assign addr_eff        = req_addr;
  assign resp_misaligned = resp_mis_q;
`else
  assign trap            = 1'b0;
  assign addr_eff        = misaligned ? (req_addr & ~{30'b0, is_word, is_word | is_half}) : req_addr;
  assign resp_misaligned = 1'b0;
`endif

  assign dmem_read    = {2'b00, addr_q[31:2]};
  assign dmem_write   = {2'b00, addr_q[31:2]};
  assign dmem_rd_en   = (state_q == LD_RD) || (state_q == ST_RD);
  assign dmem_wr_en   = (state_q == ST_WR);
  assign dmem_in_data = merge_q;

  assign resp_valid = resp_valid_q;
  assign resp_rd    = resp_rd_q;
  assign resp_data  = resp_data_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && !trap) begin
          if (req_is_store) state_d = is_word ? ST_WR : ST_RD;
          else              state_d = LD_RD;
        end
      end
      LD_RD:   state_d = LD_CAP;
      LD_CAP:  state_d = IDLE;
      ST_RD:   state_d = ST_CAP;
      ST_CAP:  state_d = ST_WR;
      ST_WR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shifted = dmem_out_data >> {addr_q[1:0], 3'b000};
    case (funct3_q[1:0])
      2'b00:   load_data = funct3_q[2] ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = funct3_q[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    merge_d = dmem_out_data;
    if (funct3_q[0]) begin
      if (addr_q[1]) merge_d[31:16] = wdata_q;
      else           merge_d[15:0]  = wdata_q;
    end else begin
      merge_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      funct3_q     <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      store_q      <= 1'b0;
      merge_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rd_q    <= '0;
      resp_data_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      trap_q       <= 1'b0;
      resp_mis_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      resp_valid_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      trap_q <= 1'b0;
      // trapped request never leaves IDLE; answer it on the edge after acceptance
      if (trap_q) begin
        resp_valid_q <= 1'b1;
        resp_rd_q    <= rd_q;
        resp_data_q  <= '0;
        resp_mis_q   <= 1'b1;
      end
`endif
      if (accept) begin
        addr_q   <= addr_eff;
        funct3_q <= req_funct3;
        wdata_q  <= req_wdata[15:0];
        rd_q     <= req_rd;
        store_q  <= req_is_store;
`ifdef LSU_MISALIGN_TRAP_EN
        trap_q   <= trap;
`endif
        if (!trap && req_is_store && is_word) merge_q <= req_wdata;
      end
      if (state_q == ST_CAP) merge_q <= merge_d;
      if ((state_q == LD_CAP) || (state_q == ST_WR)) begin
        resp_valid_q <= 1'b1;
        resp_rd_q    <= store_q ? 5'd0 : rd_q;
        resp_data_q  <= store_q ? 32'd0 : load_data;
`ifdef LSU_MISALIGN_TRAP_EN
        resp_mis_q   <= 1'b0;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// tb_lsu_mem_stage: scoreboard-driven bench for lsu_mem_stage with a behavioural word memory.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [4:0]  req_rd = 5'd0;
  logic        resp_valid;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        resp_misaligned;
  logic [31:0] dmem_read, dmem_write, dmem_in_data;
  logic        dmem_rd_en, dmem_wr_en;
  logic [31:0] dmem_out_data = 32'h0;

  lsu_mem_stage dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_data(resp_data),
    .resp_misaligned(resp_misaligned),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_rd_en(dmem_rd_en),
    .dmem_wr_en(dmem_wr_en), .dmem_in_data(dmem_in_data), .dmem_out_data(dmem_out_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (dmem_rd_en) dmem_out_data <= mem[dmem_read[5:0]];
    if (dmem_wr_en) mem[dmem_write[5:0]] <= dmem_in_data;
  end

  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  logic [31:0] last_wr_addr = 32'hFFFF_FFFF;
  always @(negedge clk) begin
    if (dmem_rd_en) rd_cnt++;
    if (dmem_wr_en) begin
      wr_cnt++;
      last_wr_addr = dmem_write;
    end
    if (dmem_rd_en && dmem_wr_en) both_cnt++;
  end

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  rd;
    int          lat;
    logic [4:0]  erd;
    logic [31:0] edata;
    logic        emis;
    int          nr;
    int          nw;
  } req_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    int          lat;
    int          nr;
    int          nw;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Drives one request at a negedge while idle; returns at the negedge where resp_valid is seen
  // (or after a 20-cycle bound). lat counts negedges after the accept edge.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd,
                        output int lat, output logic [4:0] o_rd, output logic [31:0] o_data,
                        output logic o_mis, output int n_rd, output int n_wr);
    int rd0, wr0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = wd; req_rd = rd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    o_rd = resp_rd; o_data = resp_data; o_mis = resp_misaligned;
    n_rd = rd_cnt - rd0;
    n_wr = wr_cnt - wr0;
  endtask

  task automatic test_reset;
    n_tests++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_in_rst: got %b want 0", req_ready);
    end
    n_tests++;
    if ({resp_valid, resp_rd, resp_data, resp_misaligned} !== 39'd0) begin
      n_fail++; $display("FAIL reset_resp: got v=%b rd=%0d data=%h mis=%b want all 0",
                         resp_valid, resp_rd, resp_data, resp_misaligned);
    end
    n_tests++;
    if ({dmem_rd_en, dmem_wr_en, dmem_read, dmem_write, dmem_in_data} !== 98'd0) begin
      n_fail++; $display("FAIL reset_dmem: got rd_en=%b wr_en=%b rd=%h wr=%h in=%h want all 0",
                         dmem_rd_en, dmem_wr_en, dmem_read, dmem_write, dmem_in_data);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_after: got %b want 1", req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_sw_lw;
    req_t t[2];
    t[0] = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd7, 2, 5'd0, 32'h0, 1'b0, 0, 1};
    t[1] = '{1'b0, 3'b010, 32'h10, 32'h0,        5'd5, 3, 5'd5, 32'hDEADBEEF, 1'b0, 1, 0};
    for (int i = 0; i < 2; i++) begin
      exp_t e, g;
      sb.push_back('{t[i].erd, t[i].edata, t[i].emis, t[i].lat, t[i].nr, t[i].nw});
      do_req(t[i].st, t[i].f3, t[i].addr, t[i].wd, t[i].rd, g.lat, g.rd, g.data, g.mis, g.nr, g.nw);
      e = sb.pop_front();
      n_tests++;
      if (g.lat !== e.lat) begin
        n_fail++; $display("FAIL sw_lw[%0d] latency: got %0d want %0d", i, g.lat, e.lat);
      end
      n_tests++;
      if ({g.rd, g.data, g.mis} !== {e.rd, e.data, e.mis} || g.nr != e.nr || g.nw != e.nw) begin
        n_fail++; $display("FAIL sw_lw[%0d] resp: got rd=%0d data=%h mis=%b nr=%0d nw=%0d want rd=%0d data=%h mis=%b nr=%0d nw=%0d",
                           i, g.rd, g.data, g.mis, g.nr, g.nw, e.rd, e.data, e.mis, e.nr, e.nw);
      end
      if (i == 0) begin
        n_tests++;
        if (last_wr_addr !== 32'd4) begin
          n_fail++; $display("FAIL sw_word_index: got %h want 00000004", last_wr_addr);
        end
      end
    end
  endtask

  task automatic test_subword;
    req_t t[19];
    t[0]  = '{1'b1, 3'b010, 32'h20, 32'h11223344, 5'd1, 2, 5'd0, 32'h0, 1'b0, 0, 1};
    t[1]  = '{1'b1, 3'b000, 32'h22, 32'hFFFFFFAB, 5'd9, 4, 5'd0, 32'h0, 1'b0, 1, 1};
    t[2]  = '{1'b0, 3'b010, 32'h20, 32'h0, 5'd2, 3, 5'd2, 32'h11AB3344, 1'b0, 1, 0};
    t[3]  = '{1'b0, 3'b000, 32'h22, 32'h0, 5'd3, 3, 5'd3, 32'hFFFFFFAB, 1'b0, 1, 0};
    t[4]  = '{1'b0, 3'b100, 32'h22, 32'h0, 5'd4, 3, 5'd4, 32'h000000AB, 1'b0, 1, 0};
    t[5]  = '{1'b1, 3'b010, 32'h24, 32'hCAFEBABE, 5'd0, 2, 5'd0, 32'h0, 1'b0, 0, 1};
    t[6]  = '{1'b1, 3'b001, 32'h26, 32'h12348001, 5'd6, 4, 5'd0, 32'h0, 1'b0, 1, 1};
    t[7]  = '{1'b0, 3'b010, 32'h24, 32'h0, 5'd8,  3, 5'd8,  32'h8001BABE, 1'b0, 1, 0};
    t[8]  = '{1'b0, 3'b001, 32'h26, 32'h0, 5'd6,  3, 5'd6,  32'hFFFF8001, 1'b0, 1, 0};
    t[9]  = '{1'b0, 3'b101, 32'h26, 32'h0, 5'd10, 3, 5'd10, 32'h00008001, 1'b0, 1, 0};
    t[10] = '{1'b0, 3'b001, 32'h24, 32'h0, 5'd11, 3, 5'd11, 32'hFFFFBABE, 1'b0, 1, 0};
    t[11] = '{1'b0, 3'b000, 32'h27, 32'h0, 5'd12, 3, 5'd12, 32'hFFFFFF80, 1'b0, 1, 0};
    t[12] = '{1'b0, 3'b100, 32'h25, 32'h0, 5'd13, 3, 5'd13, 32'h000000BA, 1'b0, 1, 0};
    t[13] = '{1'b1, 3'b000, 32'h20, 32'h0000005A, 5'd0, 4, 5'd0, 32'h0, 1'b0, 1, 1};
    t[14] = '{1'b0, 3'b011, 32'h20, 32'h0, 5'd14, 3, 5'd14, 32'h11AB335A, 1'b0, 1, 0};
    t[15] = '{1'b1, 3'b111, 32'h28, 32'h01020304, 5'd0, 2, 5'd0, 32'h0, 1'b0, 0, 1};
    t[16] = '{1'b0, 3'b110, 32'h28, 32'h0, 5'd15, 3, 5'd15, 32'h01020304, 1'b0, 1, 0};
    t[17] = '{1'b1, 3'b101, 32'h28, 32'h0000BEEF, 5'd0, 4, 5'd0, 32'h0, 1'b0, 1, 1};
    t[18] = '{1'b0, 3'b111, 32'h28, 32'h0, 5'd16, 3, 5'd16, 32'h0102BEEF, 1'b0, 1, 0};
    for (int i = 0; i < 19; i++) begin
      exp_t e, g;
      sb.push_back('{t[i].erd, t[i].edata, t[i].emis, t[i].lat, t[i].nr, t[i].nw});
      do_req(t[i].st, t[i].f3, t[i].addr, t[i].wd, t[i].rd, g.lat, g.rd, g.data, g.mis, g.nr, g.nw);
      e = sb.pop_front();
      n_tests++;
      if (g.lat !== e.lat) begin
        n_fail++; $display("FAIL subword[%0d] latency: got %0d want %0d", i, g.lat, e.lat);
      end
      n_tests++;
      if ({g.rd, g.data, g.mis} !== {e.rd, e.data, e.mis} || g.nr != e.nr || g.nw != e.nw) begin
        n_fail++; $display("FAIL subword[%0d] resp: got rd=%0d data=%h mis=%b nr=%0d nw=%0d want rd=%0d data=%h mis=%b nr=%0d nw=%0d",
                           i, g.rd, g.data, g.mis, g.nr, g.nw, e.rd, e.data, e.mis, e.nr, e.nw);
      end
    end
    n_tests++;
    if (mem[8] !== 32'h11AB335A || mem[9] !== 32'h8001BABE) begin
      n_fail++; $display("FAIL subword_mem: got %h %h want 11ab335a 8001babe", mem[8], mem[9]);
    end
  endtask

  task automatic test_back_to_back;
    int lat, nr, nw;
    logic [4:0] r;
    logic [31:0] d;
    logic m;
    do_req(1'b1, 3'b010, 32'h2C, 32'h0000A5A5, 5'd0, lat, r, d, m, nr, nw);
    n_tests++;
    if (resp_valid !== 1'b1 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready: got valid=%b ready=%b want 1 1", resp_valid, req_ready);
    end
    sb.push_back('{5'd17, 32'h0000A5A5, 1'b0, 3, 1, 0});
    do_req(1'b0, 3'b010, 32'h2C, 32'h0, 5'd17, lat, r, d, m, nr, nw);
    begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      if (lat !== e.lat || r !== e.rd || d !== e.data) begin
        n_fail++; $display("FAIL b2b_load: got lat=%0d rd=%0d data=%h want lat=%0d rd=%0d data=%h",
                           lat, r, d, e.lat, e.rd, e.data);
      end
    end
    @(negedge clk);
    n_tests++;
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL resp_pulse_width: got %b want 0", resp_valid);
    end
  endtask

  task automatic test_reset_abort;
    int lat, nr, nw, wr0, hi;
    logic [4:0] r;
    logic [31:0] d;
    logic m;
    do_req(1'b1, 3'b010, 32'h30, 32'h55667788, 5'd0, lat, r, d, m, nr, nw);
    do_req(1'b0, 3'b010, 32'h30, 32'h0, 5'd11, lat, r, d, m, nr, nw);
    wr0 = wr_cnt;
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h31; req_wdata = 32'h000000EE; req_rd = 5'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if (dmem_rd_en !== 1'b0 || dmem_wr_en !== 1'b0 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_immediate: got rd_en=%b wr_en=%b ready=%b valid=%b want 0 0 0 0",
                         dmem_rd_en, dmem_wr_en, req_ready, resp_valid);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hi = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid === 1'b1) hi++;
    end
    n_tests++;
    if (hi != 0 || wr_cnt != wr0) begin
      n_fail++; $display("FAIL abort_no_activity: got resp_pulses=%0d writes=%0d want 0 0", hi, wr_cnt - wr0);
    end
    n_tests++;
    if (mem[12] !== 32'h55667788) begin
      n_fail++; $display("FAIL abort_mem: got %h want 55667788", mem[12]);
    end
    n_tests++;
    if ({resp_rd, resp_data, dmem_read, dmem_write, dmem_in_data} !== 133'd0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_outputs: got rd=%0d data=%h rd_addr=%h wr_addr=%h in=%h ready=%b want zeros ready=1",
                         resp_rd, resp_data, dmem_read, dmem_write, dmem_in_data, req_ready);
    end
    do_req(1'b0, 3'b010, 32'h30, 32'h0, 5'd18, lat, r, d, m, nr, nw);
    n_tests++;
    if (lat != 3 || r !== 5'd18 || d !== 32'h55667788) begin
      n_fail++; $display("FAIL abort_recover: got lat=%0d rd=%0d data=%h want 3 18 55667788", lat, r, d);
    end
  endtask

  task automatic test_misaligned;
    req_t t[4];
`ifdef LSU_MISALIGN_TRAP_EN
    t[0] = '{1'b0, 3'b010, 32'h13, 32'h0, 5'd8,  2, 5'd8,  32'h0, 1'b1, 0, 0};
    t[1] = '{1'b0, 3'b001, 32'h27, 32'h0, 5'd9,  2, 5'd9,  32'h0, 1'b1, 0, 0};
    t[2] = '{1'b1, 3'b010, 32'h2E, 32'h77777777, 5'd10, 2, 5'd10, 32'h0, 1'b1, 0, 0};
    t[3] = '{1'b0, 3'b010, 32'h2C, 32'h0, 5'd19, 3, 5'd19, 32'h0000A5A5, 1'b0, 1, 0};
`else
    t[0] = '{1'b0, 3'b010, 32'h13, 32'h0, 5'd8,  3, 5'd8,  32'hDEADBEEF, 1'b0, 1, 0};
    t[1] = '{1'b0, 3'b001, 32'h27, 32'h0, 5'd9,  3, 5'd9,  32'hFFFF8001, 1'b0, 1, 0};
    t[2] = '{1'b1, 3'b010, 32'h2E, 32'h77777777, 5'd10, 2, 5'd0, 32'h0, 1'b0, 0, 1};
    t[3] = '{1'b0, 3'b010, 32'h2C, 32'h0, 5'd19, 3, 5'd19, 32'h77777777, 1'b0, 1, 0};
`endif
    for (int i = 0; i < 4; i++) begin
      exp_t e, g;
      sb.push_back('{t[i].erd, t[i].edata, t[i].emis, t[i].lat, t[i].nr, t[i].nw});
      do_req(t[i].st, t[i].f3, t[i].addr, t[i].wd, t[i].rd, g.lat, g.rd, g.data, g.mis, g.nr, g.nw);
      e = sb.pop_front();
      n_tests++;
      if (g.lat !== e.lat) begin
        n_fail++; $display("FAIL misaligned[%0d] latency: got %0d want %0d", i, g.lat, e.lat);
      end
      n_tests++;
      if ({g.rd, g.data, g.mis} !== {e.rd, e.data, e.mis} || g.nr != e.nr || g.nw != e.nw) begin
        n_fail++; $display("FAIL misaligned[%0d] resp: got rd=%0d data=%h mis=%b nr=%0d nw=%0d want rd=%0d data=%h mis=%b nr=%0d nw=%0d",
                           i, g.rd, g.data, g.mis, g.nr, g.nw, e.rd, e.data, e.mis, e.nr, e.nw);
      end
`ifndef LSU_MISALIGN_TRAP_EN
      if (i == 0) begin
        n_tests++;
        if (dmem_read !== 32'd4) begin
          n_fail++; $display("FAIL misaligned_word_index: got %h want 00000004", dmem_read);
        end
      end
`endif
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_sw_lw();
    test_subword();
    test_back_to_back();
    test_reset_abort();
    test_misaligned();
    n_tests++;
    if (both_cnt != 0) begin
      n_fail++; $display("FAIL strobe_exclusive: got %0d overlapping cycles want 0", both_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
